// File: rtl/lspc_vram_slot_sched.sv
// VRAM slot scheduler: each 16-phase period has slot V (video only) and slot C (CPU first, video may borrow).
// CPU access completes within 24 enables of acceptance; CPU_REQ is dropped while CPU_BUSY is high.
module lspc_vram_slot_sched #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          CLK,
  input  logic          nRESETP,
  input  logic          CLK_EN_24M_P,
  input  logic [3:0]    PHASE,
  input  logic          CPU_REQ,
  input  logic          CPU_WE,
  input  logic [AW-1:0] CPU_ADDR,
  input  logic [DW-1:0] CPU_WDATA,
  output logic          CPU_BUSY,
  output logic          CPU_ACK,
  output logic [DW-1:0] CPU_RDATA,
  input  logic          VID_REQ,
  input  logic [AW-1:0] VID_ADDR,
  output logic          VID_VALID,
  output logic [DW-1:0] VID_DATA,
  output logic [AW-1:0] VRAM_ADDR,
  output logic [DW-1:0] VRAM_WDATA,
  output logic          VRAM_WE,
  input  logic [DW-1:0] VRAM_DIN
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_STB, S_LATCH, S_REL} state_t;
  typedef enum logic [1:0] {O_NONE, O_VID, O_CPU} owner_t;

  state_t        state;
  owner_t        owner;
  logic [3:0]    prev_phase;
  logic          phase_seen;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          phase_cont;
  logic [2:0]    slot_ph;

  // A slot only runs while the phase count advances by exactly one per enable.
  assign phase_cont = phase_seen && (PHASE == prev_phase + 4'd1);
  assign slot_ph    = PHASE[2:0];

  always_ff @(posedge CLK) begin
    if (!nRESETP) begin
      state      <= S_IDLE;
      owner      <= O_NONE;
      prev_phase <= '0;
      phase_seen <= 1'b0;
      cpu_we     <= 1'b0;
      cpu_addr   <= '0;
      cpu_wdata  <= '0;
      CPU_BUSY   <= 1'b0;
      CPU_ACK    <= 1'b0;
      CPU_RDATA  <= '0;
      VID_VALID  <= 1'b0;
      VID_DATA   <= '0;
      VRAM_ADDR  <= '0;
      VRAM_WDATA <= '0;
      VRAM_WE    <= 1'b0;
    end else begin
      CPU_ACK   <= 1'b0;
      VID_VALID <= 1'b0;

      if (CPU_ACK) begin
        CPU_BUSY <= 1'b0;
      end else if (CPU_REQ && !CPU_BUSY) begin
        CPU_BUSY  <= 1'b1;
        cpu_we    <= CPU_WE;
        cpu_addr  <= CPU_ADDR;
        cpu_wdata <= CPU_WDATA;
      end

      if (CLK_EN_24M_P) begin
        prev_phase <= PHASE;
        phase_seen <= 1'b1;
        if (!phase_cont) begin
          state   <= S_IDLE;
          owner   <= O_NONE;
          VRAM_WE <= 1'b0;
        end else if (slot_ph == 3'd7) begin
          // Grant edge: PHASE 7 opens slot C, PHASE 15 opens slot V.
          VRAM_WE <= 1'b0;
          if (!PHASE[3] && CPU_BUSY) begin
            state      <= S_ADDR;
            owner      <= O_CPU;
            VRAM_ADDR  <= cpu_addr;
            VRAM_WDATA <= cpu_wdata;
          end else if (VID_REQ) begin
            state     <= S_ADDR;
            owner     <= O_VID;
            VRAM_ADDR <= VID_ADDR;
          end else begin
            state <= S_IDLE;
            owner <= O_NONE;
          end
        end else begin
          case (state)
            S_ADDR: begin
              if (slot_ph == 3'd1) begin
                state   <= S_STB;
                VRAM_WE <= (owner == O_CPU) && cpu_we;
              end
            end
            S_STB: begin
              if (slot_ph == 3'd5) begin
                state   <= S_LATCH;
                VRAM_WE <= 1'b0;
              end
            end
            S_LATCH: begin
              if (slot_ph == 3'd6) begin
                state <= S_REL;
                if (owner == O_CPU) begin
                  CPU_ACK <= 1'b1;
                  if (!cpu_we) CPU_RDATA <= VRAM_DIN;
                end else begin
                  VID_VALID <= 1'b1;
                  VID_DATA  <= VRAM_DIN;
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/lspc_vram_slot_sched.md
# lspc_vram_slot_sched

VRAM access slot scheduler for the LSPC. It time-multiplexes the single VRAM port between video fetch and 68k CPU accesses. Each 1.5 MHz period (16 LSPC 24 MHz phases) is split into two 8-phase slots, sequenced from the LSPC clock generator's phase count. The block sits between the clock generator, the CPU register interface and the sprite/fix fetch logic, and drives the VRAM address, data and write-enable lines.

## Interface
Parameters:
- AW, 16, VRAM word address width
- DW, 16, VRAM data width

Ports:
- CLK  in  1  system clock; all state changes on posedge
- nRESETP  in  1  reset, synchronous, active-low
- CLK_EN_24M_P  in  1  24M rising-edge enable; the block acts only on cycles where this is high
- PHASE  in  4  phase count from the clock generator (0..15), valid on enable cycles
- CPU_REQ  in  1  one-cycle request strobe
- CPU_WE  in  1  1 = write, 0 = read; sampled with CPU_REQ
- CPU_ADDR  in  AW  sampled with CPU_REQ
- CPU_WDATA  in  DW  sampled with CPU_REQ
- CPU_BUSY  out  1  request pending or in flight
- CPU_ACK  out  1  one-cycle completion pulse
- CPU_RDATA  out  DW  read data; held until the next CPU read completes
- VID_REQ  in  1  level; video wants a read in the next slot
- VID_ADDR  in  AW  video read address; sampled at slot grant
- VID_VALID  out  1  one-cycle pulse; VID_DATA valid
- VID_DATA  out  DW  video read data
- VRAM_ADDR  out  AW  VRAM address
- VRAM_WDATA  out  DW  VRAM write data
- VRAM_WE  out  1  VRAM write strobe, active-high
- VRAM_DIN  in  DW  VRAM read data

## Operation
- Two slots per period:
  - Slot V starts at PHASE 0 and is video-only.
  - Slot C starts at PHASE 8. The CPU owns it if a request is pending; otherwise video may borrow it.
- Grant decision is made on the enable cycle with PHASE == slot start − 1 (15 for V, 7 for C):
  - V: owner = VID if VID_REQ, else NONE.
  - C: owner = CPU if pending, else VID if VID_REQ, else NONE.
  - The granted address (and data/WE for CPU) is latched into the VRAM_* registers.
- Per-slot state machine, advanced on enables:
  - IDLE → ADDR (slot phases 0–1) → STB (phases 2–5) → LATCH (phase 6) → REL (phase 7) → IDLE.
  - With owner NONE the machine stays IDLE and VRAM_WE is 0.
- VRAM_WE = 1 only in STB with owner CPU and the latched WE = 1. Video accesses are always reads.
- LATCH:
  - A read captures VRAM_DIN into VID_DATA or CPU_RDATA.
  - The matching VID_VALID or CPU_ACK pulses for exactly one CLK cycle.
  - CPU writes also pulse CPU_ACK here.
- CPU handshake:
  - CPU_REQ is accepted only when CPU_BUSY = 0. It latches WE/ADDR/WDATA and sets CPU_BUSY the next cycle.
  - CPU_REQ while busy is ignored, and so is CPU_REQ in the same cycle as CPU_ACK.
  - CPU_BUSY clears in the cycle after CPU_ACK.
- A request accepted after the PHASE 7 decision waits for the next period's slot C. Worst-case latency is 24 enables.
- Phase discontinuity: if an enable arrives with PHASE ≠ expected (previous + 1 mod 16), for example after the clock generator resets:
  - Any active slot aborts to IDLE with no ACK/VALID, and VRAM_WE drops on that edge.
  - A pending CPU request stays pending and is retried at the next valid grant.
- Reset values:
  - owner NONE, state IDLE.
  - CPU_BUSY, CPU_ACK, VID_VALID, VRAM_WE = 0.
  - VRAM_ADDR, VRAM_WDATA, CPU_RDATA, VID_DATA = 0.
  - Pending request cleared.
  - Reset mid-slot: VRAM_WE = 0 in the first cycle after the reset edge, and no ACK is issued.

## Timing
- All outputs are registered; nothing reacts to the inputs combinationally.
- VRAM_ADDR is stable from the grant edge through slot phase 7. It changes only at a grant edge or on reset.
- VRAM_WE rises on the enable edge ending slot phase 1 and falls on the edge ending phase 5. That is 4 enables, i.e. 4 × 24M periods.
- VRAM_DIN is sampled on the LATCH enable (PHASE 6 or 14). ACK/VALID go high in the CLK cycle after that edge, for one cycle.
- Phase tracking starts at the first enable after reset. No grant is made until one valid predecessor phase has been observed.

## Test plan
- Video only, VID_REQ = 1 constant, VID_ADDR = 0x1234, VRAM_DIN = 0xBEEF → two VID_VALID pulses per period (after PHASE 6 and PHASE 14) with VID_DATA = 0xBEEF; VRAM_WE never high.
- CPU write 0x7000 ← 0xA5A5 requested at PHASE 3 → VRAM_ADDR = 0x7000 from PHASE 8; VRAM_WE high for PHASE 10–13 with VRAM_WDATA = 0xA5A5; CPU_ACK after PHASE 14; BUSY low one cycle later.
- CPU read requested at PHASE 9 with VID_REQ = 1 → slot C of that period goes to video; the CPU is served at PHASE 8 of the next period; CPU_RDATA = VRAM_DIN at PHASE 14.
- CPU_REQ pulsed twice while BUSY → only the first is executed; exactly one CPU_ACK.
- PHASE jumps 10 → 2 during a CPU write → VRAM_WE drops immediately, no ACK, BUSY stays 1; the write completes in the next valid slot C.
- nRESETP low at PHASE 11 during a CPU write → all outputs 0 the cycle after the edge, BUSY 0, no ACK after release.
